// File: rtl/cdc_pkg.sv
// ----------------------------------------------------------------------------
// cdc_pkg
// Shared clock-domain-crossing definitions.
// - hs_rx_state_t     : states of the slow-side four-phase handshake receiver
// - MIN/MAX_SYNC_STAGES : legal depth of a request synchronizer chain
// - sync_stages_legal() : elaboration-time range check used by the receiver
// ----------------------------------------------------------------------------
package cdc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        STALL,
        ACK,
        DRAIN
    } hs_rx_state_t;

    localparam int MIN_SYNC_STAGES = 2;
    localparam int MAX_SYNC_STAGES = 4;

    function automatic bit sync_stages_legal(input int stages);
        return (stages >= MIN_SYNC_STAGES) && (stages <= MAX_SYNC_STAGES);
    endfunction

endpackage

// File: rtl/cdc_sync_bits.sv
// ----------------------------------------------------------------------------
// cdc_sync_bits
// Generic multi-flop synchronizer chain, one chain per bit of d.
// Only level signals that change slowly relative to clk may pass through it;
// multi-bit buses must be Gray-coded or otherwise single-bit-changing.
// Ports:
//   clk    in   destination clock
//   rst_ni in   asynchronous active-low reset, clears every stage
//   d      in   WIDTH  asynchronous input
//   q      out  WIDTH  synchronized output (last stage)
// ----------------------------------------------------------------------------
module cdc_sync_bits #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [STAGES];

    // NOTE: the stage array is a flop chain, not a RAM, so every element is
    // reset; a known-zero chain keeps a spurious request from appearing
    // right after reset.
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < STAGES; i++) begin
                stage[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments make every stage take the value
            // its predecessor had before this edge, which is what a shift
            // chain means; blocking would collapse the chain into one flop.
            stage[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[STAGES-1];

endmodule

// File: rtl/cdc_hs_rx_slow.sv
// ----------------------------------------------------------------------------
// cdc_hs_rx_slow
// Receiving end of a four-phase req/ack handshake that moves a data word from
// a faster domain into clk_slow. The request is synchronized, the sender-held
// word is captured once the synchronized request is seen, and a registered
// level acknowledge is returned. The word is presented through a one-entry
// valid/ready buffer with backpressure.
// Ports:
//   clk_slow    in   receiving-domain clock
//   rst_ni      in   asynchronous active-low reset
//   req_i       in   request level from the sender (asynchronous)
//   data_i      in   DATA_WIDTH sender word, stable while req_i is high
//   ack_o       out  acknowledge level back to the sender (registered)
//   valid_o     out  data_o holds an undelivered word
//   ready_i     in   consumer accepts when valid_o && ready_i at an edge
//   data_o      out  DATA_WIDTH captured word
//   xfer_cnt_o  out  CNT_WIDTH completed-handshake counter (wraps)
//   proto_err_o out  sticky: request withdrawn before it was acknowledged
// ----------------------------------------------------------------------------
module cdc_hs_rx_slow
    import cdc_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                  clk_slow,
    input  logic                  rst_ni,
    input  logic                  req_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  ack_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic [CNT_WIDTH-1:0]  xfer_cnt_o,
    output logic                  proto_err_o
);

    if (!sync_stages_legal(SYNC_STAGES)) begin : g_bad_sync_stages
        $error("cdc_hs_rx_slow: SYNC_STAGES must lie in 2..4");
    end

    hs_rx_state_t state;
    logic         req_s;
    logic         buf_free;
    logic         pop;

    cdc_sync_bits #(
        .WIDTH (1),
        .STAGES(SYNC_STAGES)
    ) u_req_sync (
        .clk   (clk_slow),
        .rst_ni(rst_ni),
        .d     (req_i),
        .q     (req_s)
    );

    // The buffer can take a new word if it is empty or is being emptied
    // at this same edge.
    assign pop      = valid_o && ready_i;
    assign buf_free = !valid_o || ready_i;

    always_ff @(posedge clk_slow or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            ack_o       <= 1'b0;
            valid_o     <= 1'b0;
            data_o      <= '0;
            xfer_cnt_o  <= '0;
            proto_err_o <= 1'b0;
        end else begin
            // A pop empties the buffer unless a capture below refills it
            // in the same cycle; the later assignment wins.
            if (pop) begin
                valid_o <= 1'b0;
            end

            unique case (state)
                IDLE: begin
                    if (req_s) begin
                        if (buf_free) begin
                            data_o  <= data_i;
                            valid_o <= 1'b1;
                            ack_o   <= 1'b1;
                            state   <= ACK;
                        end else begin
                            state <= STALL;
                        end
                    end
                end
                STALL: begin
                    // The sender may not withdraw a request it has not seen
                    // acknowledged; flag it and drop the word.
                    if (!req_s) begin
                        proto_err_o <= 1'b1;
                        state       <= IDLE;
                    end else if (buf_free) begin
                        data_o  <= data_i;
                        valid_o <= 1'b1;
                        ack_o   <= 1'b1;
                        state   <= ACK;
                    end
                end
                ACK: begin
                    if (!req_s) begin
                        ack_o <= 1'b0;
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // One guaranteed low-ack cycle before the next request
                    // can be accepted.
                    xfer_cnt_o <= xfer_cnt_o + CNT_WIDTH'(1);
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cdc_hs_rx_slow.sv
`timescale 1ns/1ps
module tb_cdc_hs_rx_slow;

    logic        clk_slow = 1'b0;
    logic        clk_fast = 1'b0;
    logic        rst_ni;
    logic        req_i;
    logic [7:0]  data_i;
    logic        ready_i;

    logic        ack_o, valid_o, proto_err_o;
    logic [7:0]  data_o;
    logic [15:0] xfer_cnt_o;

    logic        ack4, valid4, err4;
    logic [7:0]  data4;
    logic [3:0]  cnt4;

    int checks   = 0;
    int failures = 0;

    cdc_hs_rx_slow #(.DATA_WIDTH(8), .SYNC_STAGES(2), .CNT_WIDTH(16)) dut (
        .clk_slow   (clk_slow),
        .rst_ni     (rst_ni),
        .req_i      (req_i),
        .data_i     (data_i),
        .ack_o      (ack_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .data_o     (data_o),
        .xfer_cnt_o (xfer_cnt_o),
        .proto_err_o(proto_err_o)
    );

    // Narrow-counter instance sharing all inputs, used for the wrap check.
    cdc_hs_rx_slow #(.DATA_WIDTH(8), .SYNC_STAGES(2), .CNT_WIDTH(4)) dut4 (
        .clk_slow   (clk_slow),
        .rst_ni     (rst_ni),
        .req_i      (req_i),
        .data_i     (data_i),
        .ack_o      (ack4),
        .valid_o    (valid4),
        .ready_i    (ready_i),
        .data_o     (data4),
        .xfer_cnt_o (cnt4),
        .proto_err_o(err4)
    );

    always #5 clk_slow = ~clk_slow;
    // 4x faster sender clock, phase-shifted so its edges never meet clk_slow's.
    initial begin
        #0.3;
        forever #1.25 clk_fast = ~clk_fast;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_slow);
        #1;
    endtask

    // One complete handshake with a free consumer.
    task automatic do_xfer(input logic [7:0] d);
        data_i = d;
        req_i  = 1'b1;
        tick(); tick(); tick();
        check("xfer_ack_high", 32'(ack_o), 32'd1);
        check("xfer_data", 32'(data_o), 32'(d));
        req_i = 1'b0;
        tick(); tick(); tick();
        check("xfer_ack_low", 32'(ack_o), 32'd0);
        tick();
    endtask

    logic [7:0] tx [100];
    logic [7:0] rx [100];
    int         n_rx;

    task automatic sender_run();
        int   sent   = 0;
        int   budget = 0;
        logic a1 = 1'b0, a2 = 1'b0;
        while ((sent < 100 || req_i || a2) && budget < 40000) begin
            @(posedge clk_fast);
            budget++;
            a2 = a1;
            a1 = ack_o;
            if (!req_i && !a2 && sent < 100) begin
                data_i = tx[sent];
                req_i  = 1'b1;
                sent++;
            end else if (req_i && a2) begin
                req_i = 1'b0;
            end
        end
        check("sender_done_in_budget", 32'(budget < 40000), 32'd1);
    endtask

    task automatic consumer_run();
        int cyc = 0;
        n_rx = 0;
        while (n_rx < 100 && cyc < 20000) begin
            @(negedge clk_slow);
            cyc++;
            ready_i = ($urandom_range(0, 3) != 0);
            if (valid_o && ready_i) begin
                rx[n_rx] = data_o;
                n_rx++;
            end
        end
        check("consumer_done_in_budget", 32'(n_rx), 32'd100);
    endtask

    initial begin
        rst_ni  = 1'b0;
        req_i   = 1'b0;
        data_i  = 8'h00;
        ready_i = 1'b0;
        #12;
        check("rst_ack", 32'(ack_o), 32'd0);
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_data", 32'(data_o), 32'd0);
        check("rst_cnt", 32'(xfer_cnt_o), 32'd0);
        check("rst_err", 32'(proto_err_o), 32'd0);
        rst_ni = 1'b1;
        tick();

        // Single transfer, free consumer.
        ready_i = 1'b1;
        data_i  = 8'hA5;
        req_i   = 1'b1;
        tick();
        check("t1_ack_k", 32'(ack_o), 32'd0);
        tick();
        check("t1_ack_k1", 32'(ack_o), 32'd0);
        check("t1_valid_k1", 32'(valid_o), 32'd0);
        tick();
        check("t1_ack_k2", 32'(ack_o), 32'd1);
        check("t1_valid_k2", 32'(valid_o), 32'd1);
        check("t1_data_k2", 32'(data_o), 32'hA5);
        req_i = 1'b0;
        tick();
        check("t1_ack_j", 32'(ack_o), 32'd1);
        check("t1_popped", 32'(valid_o), 32'd0);
        tick();
        check("t1_ack_j1", 32'(ack_o), 32'd1);
        tick();
        check("t1_ack_j2", 32'(ack_o), 32'd0);
        check("t1_cnt_j2", 32'(xfer_cnt_o), 32'd0);
        tick();
        check("t1_cnt_j3", 32'(xfer_cnt_o), 32'd1);

        // Backpressure: 8'h11 held, 8'h22 waits in STALL.
        ready_i = 1'b0;
        do_xfer(8'h11);
        check("t2_cnt", 32'(xfer_cnt_o), 32'd2);
        check("t2_held", 32'(valid_o), 32'd1);
        data_i = 8'h22;
        req_i  = 1'b1;
        tick(); tick(); tick(); tick();
        check("t2_stall_ack", 32'(ack_o), 32'd0);
        check("t2_stall_data", 32'(data_o), 32'h11);
        ready_i = 1'b1;
        tick();
        check("t2_replace_data", 32'(data_o), 32'h22);
        check("t2_replace_valid", 32'(valid_o), 32'd1);
        check("t2_replace_ack", 32'(ack_o), 32'd1);
        ready_i = 1'b0;
        req_i   = 1'b0;
        tick(); tick(); tick(); tick();
        check("t2_cnt_after", 32'(xfer_cnt_o), 32'd3);
        check("t2_ack_after", 32'(ack_o), 32'd0);

        // Protocol violation: request withdrawn while stalled.
        data_i = 8'h33;
        req_i  = 1'b1;
        tick(); tick(); tick();
        check("t3_stall_ack", 32'(ack_o), 32'd0);
        req_i = 1'b0;
        tick(); tick();
        check("t3_err_not_yet", 32'(proto_err_o), 32'd0);
        tick();
        check("t3_err_set", 32'(proto_err_o), 32'd1);
        tick(); tick(); tick();
        check("t3_err_sticky", 32'(proto_err_o), 32'd1);
        check("t3_no_capture", 32'(data_o), 32'h22);
        check("t3_cnt_same", 32'(xfer_cnt_o), 32'd3);

        // Reset during ACK.
        ready_i = 1'b1;
        tick();
        check("t4_drained", 32'(valid_o), 32'd0);
        data_i = 8'h44;
        req_i  = 1'b1;
        tick(); tick(); tick();
        check("t4_in_ack", 32'(ack_o), 32'd1);
        rst_ni = 1'b0;
        #2;
        check("t4_rst_ack", 32'(ack_o), 32'd0);
        check("t4_rst_valid", 32'(valid_o), 32'd0);
        check("t4_rst_data", 32'(data_o), 32'd0);
        check("t4_rst_cnt", 32'(xfer_cnt_o), 32'd0);
        check("t4_rst_err", 32'(proto_err_o), 32'd0);
        req_i = 1'b0;
        #2;
        rst_ni = 1'b1;
        tick();
        do_xfer(8'h55);
        check("t4_cnt_after", 32'(xfer_cnt_o), 32'd1);

        // Random stream from a 4x-faster sender, random consumer.
        for (int i = 0; i < 100; i++) tx[i] = 8'($urandom_range(0, 255));
        fork
            sender_run();
            consumer_run();
        join
        tick(); tick(); tick();
        for (int i = 0; i < 100; i++) begin
            if (i < n_rx) check($sformatf("stream_word_%0d", i), 32'(rx[i]), 32'(tx[i]));
        end
        check("stream_cnt", 32'(xfer_cnt_o), 32'd101);
        check("stream_err", 32'(proto_err_o), 32'd0);

        // Counter wrap with CNT_WIDTH=4.
        ready_i = 1'b1;
        rst_ni  = 1'b0;
        #3;
        rst_ni = 1'b1;
        tick();
        for (int i = 0; i < 17; i++) do_xfer(8'(i + 8'h60));
        check("wrap_cnt16", 32'(xfer_cnt_o), 32'd17);
        check("wrap_cnt4", 32'(cnt4), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cdc_hs_rx_slow.md
# cdc_hs_rx_slow

Receiving end of a four-phase req/ack handshake that carries a data word from a faster clock domain into the clk_slow domain. It is the counterpart to the level-only two-flop synchronizer, which cannot carry fast-to-slow traffic without dropping transitions. The block synchronizes the incoming request, captures the sender-held word, and returns a level acknowledge. It presents the word to slow-domain logic through a valid/ready interface with backpressure.

## Interface
- DATA_WIDTH, 8: width of the transferred word.
- SYNC_STAGES, 2: flops in the req synchronizer chain; legal range 2..4.
- CNT_WIDTH, 16: width of the completed-transfer counter.

- clk_slow  in  1  receiving-domain clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- req_i  in  1  request level from the sender domain; asynchronous to clk_slow.
- data_i  in  DATA_WIDTH  sender word; stable whenever req_i is high; not synchronized.
- ack_o  out  1  acknowledge level back to the sender; registered, glitch-free.
- valid_o  out  1  data_o holds an undelivered word.
- ready_i  in  1  consumer accepts the word when valid_o and ready_i are both high at a clk_slow edge.
- data_o  out  DATA_WIDTH  captured word.
- xfer_cnt_o  out  CNT_WIDTH  count of completed handshakes; wraps modulo 2^CNT_WIDTH.
- proto_err_o  out  1  sticky error: req dropped while the block was waiting to acknowledge it.

## Operation
- req_s is the last stage of the SYNC_STAGES chain on req_i. The FSM uses only req_s.
- Output buffer: one entry (valid_o, data_o). buf_free = !valid_o || ready_i.
- IDLE, ack_o=0:
  - req_s=1 and buf_free: load data_o<=data_i, set valid_o=1, go to ACK.
  - req_s=1 and !buf_free: go to STALL.
- STALL, ack_o=0:
  - buf_free and req_s=1: capture as in IDLE, go to ACK.
  - req_s=0: set proto_err_o=1, go to IDLE, no capture.
- ACK, ack_o=1: stay until req_s=0, then go to DRAIN.
- DRAIN, ack_o=0: increment xfer_cnt_o, go to IDLE. This state guarantees one low ack cycle between transfers.
- Simultaneous pop and capture in the same cycle: the new word replaces the popped one and valid_o stays 1.
- A pop with no capture clears valid_o.
- proto_err_o clears only on reset. Reset mid-transfer drops ack_o immediately; the sender must restart its handshake.

## Timing
- Reset values: ack_o=0, valid_o=0, data_o=0, xfer_cnt_o=0, proto_err_o=0, FSM=IDLE, synchronizer flops=0.
- If req_i is first sampled high at edge k, then with a free buffer valid_o and ack_o both rise at edge k+SYNC_STAGES.
- If req_i is first sampled low at edge j while in ACK:
  - ack_o falls at edge j+SYNC_STAGES (entering DRAIN).
  - xfer_cnt_o increments at edge j+SYNC_STAGES+1.
- Minimum full cycle is 2*SYNC_STAGES+1 clk_slow cycles, plus the sender's own synchronizer delay.
- data_i is sampled only in the capture cycle, at least SYNC_STAGES cycles after req_i rose.
- All outputs are registers. There are no combinational paths from inputs to outputs.

## Structure
- Package cdc_pkg holds:
  - typedef enum logic [1:0] hs_rx_state_t {IDLE, STALL, ACK, DRAIN};
  - constants MIN_SYNC_STAGES=2 and MAX_SYNC_STAGES=4;
  - an elaboration-time range check on SYNC_STAGES.
- One sub-module, cdc_sync_bits (params WIDTH, STAGES), is the generic flop chain. The team reuses it on the sender side for ack.
- The top level contains the FSM, the output buffer and the counter.

## Test plan
- Single transfer, SYNC_STAGES=2, ready_i=1, data_i=8'hA5: req_i high -> valid_o and ack_o at edge k+2, data_o=8'hA5. Then req_i low -> ack_o low at j+2, xfer_cnt_o=1.
- Backpressure: ready_i=0 with word 8'h11 held; second req with 8'h22 -> FSM in STALL, ack_o stays 0. Raise ready_i -> 8'h11 popped and 8'h22 captured in the same cycle, valid_o stays 1.
- Protocol violation: req_i pulsed high then low while in STALL -> proto_err_o=1 and sticky, no capture, xfer_cnt_o unchanged.
- Stream of 100 random words from a 4x-faster sender model with random ready_i -> received sequence equals sent sequence, xfer_cnt_o=100, proto_err_o=0.
- Reset asserted during ACK -> all outputs return to reset values asynchronously. After release, the next handshake completes normally.
- CNT_WIDTH=4 with 17 transfers -> xfer_cnt_o wraps to 1.
